// File: rtl/gfx_rom_arbiter.sv
// Round-robin arbiter sharing one SDRAM graphics-ROM read port between NUM_REQ fetch clients.
// Optional macro GFX_ROM_ARB_TIMEOUT_EN: abandon a read after 255 WAIT cycles and return zero data.
module gfx_rom_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 20,
  parameter int DW      = 32
) (
  input  logic                  CLK_32M,
  input  logic                  RESET_N,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  output logic [NUM_REQ-1:0]    rsp_rdy,
  output logic [DW-1:0]         rsp_data,
  output logic                  busy,
  output logic [AW-1:0]         sdr_addr,
  output logic                  sdr_req,
  input  logic                  sdr_rdy,
  input  logic [DW-1:0]         sdr_data,
  output logic [1:0]            o_dbg_state
);

  // Handshake: req[i] and sdr_rdy are single-cycle strobes with no back-pressure; the
  // arbiter keeps exactly one SDRAM read in flight (sdr_req pulse, then wait for sdr_rdy).
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [NUM_REQ-1:0]  r_pend;
  logic [AW-1:0]       r_addr [NUM_REQ];
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_gnt;
  logic [AW-1:0]       r_sdr_addr;
  logic                r_sdr_req;
  logic [NUM_REQ-1:0]  r_rsp_rdy;
  logic [DW-1:0]       r_rsp_data;

  logic [NUM_REQ-1:0]  w_pend_eff;
  logic                w_any;
  logic [PW-1:0]       w_sel;
  logic [PW:0]         w_idx;
  logic [AW-1:0]       w_sel_addr;
  logic                w_grant;
  logic                w_done;
  logic                w_timeout;

  // A request arriving while idle is granted straight from the port, saving a cycle.
  assign w_pend_eff = r_pend | req;
  assign w_any      = |w_pend_eff;
  assign w_grant    = (r_state == S_IDLE) && w_any;
  assign w_done     = (r_state == S_WAIT) && (sdr_rdy || w_timeout);

  always_comb begin
    w_sel = '0;
    w_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NUM_REQ)) w_idx = w_idx - (PW+1)'(NUM_REQ);
      if (w_pend_eff[w_idx[PW-1:0]]) w_sel = w_idx[PW-1:0];
    end
  end

  // A latched request takes precedence so a coincident new pulse is kept for the next grant.
  always_comb begin
    w_sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == PW'(i)) w_sel_addr = r_pend[i] ? r_addr[i] : req_addr[i*AW +: AW];
    end
  end

`ifdef GFX_ROM_ARB_TIMEOUT_EN
  logic [7:0] r_wait_cnt;

  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  assign w_timeout = (r_wait_cnt == 8'd255);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT:  if (w_done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      r_pend     <= '0;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_sdr_addr <= '0;
      r_sdr_req  <= 1'b0;
      r_rsp_rdy  <= '0;
      r_rsp_data <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_addr[i] <= '0;
    end else begin
      r_sdr_req <= 1'b0;
      r_rsp_rdy <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant && (w_sel == PW'(i))) r_pend[i] <= r_pend[i] & req[i];
        else if (req[i])                  r_pend[i] <= 1'b1;
        if (req[i]) r_addr[i] <= req_addr[i*AW +: AW];
      end
      if (w_grant) begin
        r_sdr_addr <= w_sel_addr;
        r_sdr_req  <= 1'b1;
        r_gnt      <= w_sel;
        r_ptr      <= (w_sel == PW'(NUM_REQ - 1)) ? '0 : w_sel + PW'(1);
      end
      if (w_done) begin
        r_rsp_data <= sdr_rdy ? sdr_data : '0;
        for (int i = 0; i < NUM_REQ; i++) r_rsp_rdy[i] <= (r_gnt == PW'(i));
      end
    end
  end

  always_comb begin
    rsp_rdy     = r_rsp_rdy;
    rsp_data    = r_rsp_data;
    sdr_addr    = r_sdr_addr;
    sdr_req     = r_sdr_req;
    busy        = (r_state != S_IDLE) || (|r_rsp_rdy);
    o_dbg_state = r_state;
  end

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// Directed bench for gfx_rom_arbiter: single read, contention, overwrite, fairness, reset, timeout.
module tb_gfx_rom_arbiter;

  localparam int NR = 3;
  localparam int AW = 20;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]   rsp_rdy;
  logic [DW-1:0]   rsp_data;
  logic            busy;
  logic [AW-1:0]   sdr_addr;
  logic            sdr_req;
  logic            sdr_rdy;
  logic [DW-1:0]   sdr_data;
  logic [1:0]      dbg_state;

  int n_pass = 0;
  int n_total = 0;

  gfx_rom_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW)) dut (
    .CLK_32M(clk), .RESET_N(rst_n), .req(req), .req_addr(req_addr),
    .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .busy(busy),
    .sdr_addr(sdr_addr), .sdr_req(sdr_req), .sdr_rdy(sdr_rdy),
    .sdr_data(sdr_data), .o_dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    sdr_rdy = 1'b0;
    sdr_data = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Advance until sdr_req is seen (possibly already in this cycle), bounded.
  task automatic wait_sdr_req(input string tag);
    int n;
    n = 0;
    while (sdr_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check(tag, sdr_req, 1'b1);
  endtask

  // Called in the sdr_req cycle; returns in the rsp_rdy cycle (sdr_rdy 2 cycles after sdr_req).
  task automatic serve(input logic [DW-1:0] data);
    tick();
    tick();
    sdr_rdy = 1'b1;
    sdr_data = data;
    tick();
    sdr_rdy = 1'b0;
    sdr_data = '0;
  endtask

  logic [1:0]    fair_exp [10];
  logic [AW-1:0] fair_addr [3];
  logic          ok;

  initial begin
    req = '0;
    req_addr = '0;
    sdr_rdy = 1'b0;
    sdr_data = '0;
    rst_n = 1'b0;

    // Reset state with junk on the inputs
    req = 3'b111;
    sdr_rdy = 1'b1;
    sdr_data = 32'h5555AAAA;
    tick();
    tick();
    check("rst_rsp_rdy", rsp_rdy, 3'b000);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_sdr_req", sdr_req, 1'b0);
    check("rst_sdr_addr", sdr_addr, 20'h0);
    check("rst_busy", busy, 1'b0);

    // Single read
    do_reset();
    set_addr(1, 20'h12345);
    req = 3'b010;
    tick();
    req = '0;
    check("single_sdr_req_c1", sdr_req, 1'b1);
    check("single_sdr_addr_c1", sdr_addr, 20'h12345);
    check("single_busy_c1", busy, 1'b1);
    tick();
    check("single_sdr_req_c2", sdr_req, 1'b0);
    check("single_busy_c2", busy, 1'b1);
    tick();
    tick();
    tick();
    check("single_no_rsp_c5", rsp_rdy, 3'b000);
    check("single_busy_c5", busy, 1'b1);
    sdr_rdy = 1'b1;
    sdr_data = 32'hDEADBEEF;
    tick();
    sdr_rdy = 1'b0;
    check("single_rsp_rdy_c6", rsp_rdy, 3'b010);
    check("single_rsp_data_c6", rsp_data, 32'hDEADBEEF);
    check("single_busy_c6", busy, 1'b1);
    tick();
    check("single_rsp_rdy_c7", rsp_rdy, 3'b000);
    check("single_busy_c7", busy, 1'b0);
    check("single_data_hold", rsp_data, 32'hDEADBEEF);
    check("single_addr_hold", sdr_addr, 20'h12345);

    // Contention: all three at once
    do_reset();
    set_addr(0, 20'h10);
    set_addr(1, 20'h20);
    set_addr(2, 20'h30);
    req = 3'b111;
    tick();
    req = '0;
    check("cont_addr0", sdr_addr, 20'h10);
    serve(32'h1111_0000);
    check("cont_rsp0", rsp_rdy, 3'b001);
    check("cont_data0", rsp_data, 32'h1111_0000);
    wait_sdr_req("cont_req1_seen");
    check("cont_addr1", sdr_addr, 20'h20);
    serve(32'h2222_0000);
    check("cont_rsp1", rsp_rdy, 3'b010);
    check("cont_data1", rsp_data, 32'h2222_0000);
    wait_sdr_req("cont_req2_seen");
    check("cont_addr2", sdr_addr, 20'h30);
    serve(32'h3333_0000);
    check("cont_rsp2", rsp_rdy, 3'b100);
    tick();
    check("cont_idle_busy", busy, 1'b0);
    check("cont_idle_req", sdr_req, 1'b0);

    // Overwrite while busy, then coincident request in the grant cycle
    do_reset();
    set_addr(2, 20'h50);
    req = 3'b100;
    tick();
    req = '0;
    check("ovw_addr2", sdr_addr, 20'h50);
    tick();
    set_addr(0, 20'h100);
    req = 3'b001;
    tick();
    set_addr(0, 20'h200);
    tick();
    req = '0;
    tick();
    sdr_rdy = 1'b1;
    sdr_data = 32'hAAAA_0002;
    tick();
    sdr_rdy = 1'b0;
    check("ovw_rsp2", rsp_rdy, 3'b100);
    set_addr(0, 20'h300);
    req = 3'b001;
    tick();
    req = '0;
    check("ovw_req_latest", sdr_req, 1'b1);
    check("ovw_addr_latest", sdr_addr, 20'h200);
    serve(32'hAAAA_0200);
    check("ovw_rsp0_a", rsp_rdy, 3'b001);
    wait_sdr_req("ovw_second_seen");
    check("ovw_addr_coinc", sdr_addr, 20'h300);
    serve(32'hAAAA_0300);
    check("ovw_rsp0_b", rsp_rdy, 3'b001);
    check("ovw_data_b", rsp_data, 32'hAAAA_0300);
    tick();
    check("ovw_no_third", sdr_req, 1'b0);
    check("ovw_busy_end", busy, 1'b0);

    // Fairness: clients 0 and 2 always requesting, client 1 pulses once at grant 4
    do_reset();
    fair_addr[0] = 20'hA0;
    fair_addr[1] = 20'hB1;
    fair_addr[2] = 20'hC2;
    fair_exp[0] = 2'd0; fair_exp[1] = 2'd2; fair_exp[2] = 2'd0; fair_exp[3] = 2'd2;
    fair_exp[4] = 2'd0; fair_exp[5] = 2'd1; fair_exp[6] = 2'd2; fair_exp[7] = 2'd0;
    fair_exp[8] = 2'd2; fair_exp[9] = 2'd0;
    for (int i = 0; i < NR; i++) set_addr(i, fair_addr[i]);
    req = 3'b101;
    for (int g = 0; g < 10; g++) begin
      wait_sdr_req($sformatf("fair_req_seen_%0d", g));
      check($sformatf("fair_addr_%0d", g), sdr_addr, fair_addr[fair_exp[g]]);
      req = (g == 4) ? 3'b111 : 3'b101;
      tick();
      req = 3'b101;
      tick();
      sdr_rdy = 1'b1;
      sdr_data = 32'hF000_0000 | 32'(g);
      tick();
      sdr_rdy = 1'b0;
      check($sformatf("fair_rsp_%0d", g), rsp_rdy, 3'b001 << fair_exp[g]);
    end
    req = '0;

    // Reset during WAIT with a pending client, then a late sdr_rdy
    do_reset();
    set_addr(1, 20'h4444);
    req = 3'b010;
    tick();
    req = '0;
    tick();
    set_addr(0, 20'h9999);
    req = 3'b001;
    tick();
    req = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_sdr_req", sdr_req, 1'b0);
    check("mid_rst_state", dbg_state, 2'd0);
    sdr_rdy = 1'b1;
    sdr_data = 32'hBAD0_BAD0;
    tick();
    sdr_rdy = 1'b0;
    check("mid_rst_late_rdy", rsp_rdy, 3'b000);
    check("mid_rst_pend_clear", sdr_req, 1'b0);
    tick();
    tick();
    check("mid_rst_still_idle", busy, 1'b0);
    set_addr(2, 20'h777);
    req = 3'b100;
    tick();
    req = '0;
    check("mid_rst_next_req", sdr_req, 1'b1);
    check("mid_rst_next_addr", sdr_addr, 20'h777);
    serve(32'h7777_7777);
    check("mid_rst_next_rsp", rsp_rdy, 3'b100);
    check("mid_rst_next_data", rsp_data, 32'h7777_7777);

    // Timeout behaviour (or the indefinite wait when the feature is absent)
    do_reset();
    set_addr(0, 20'h1);
    req = 3'b001;
    tick();
    req = '0;
    serve(32'hCAFE_F00D);
    check("to_pre_data", rsp_data, 32'hCAFE_F00D);
    set_addr(1, 20'h2);
    req = 3'b010;
    tick();
    req = '0;
    check("to_issue", sdr_req, 1'b1);
    tick();
    check("to_wait_state", dbg_state, 2'd2);
`ifdef GFX_ROM_ARB_TIMEOUT_EN
    ok = 1'b1;
    for (int c = 0; c < 255; c++) begin
      tick();
      if (rsp_rdy !== 3'b000 || busy !== 1'b1) ok = 1'b0;
    end
    check("to_quiet_255", ok, 1'b1);
    tick();
    check("to_rsp_rdy", rsp_rdy, 3'b010);
    check("to_rsp_data", rsp_data, 32'h0);
    sdr_rdy = 1'b1;
    sdr_data = 32'h1234_5678;
    tick();
    sdr_rdy = 1'b0;
    check("to_late_rdy", rsp_rdy, 3'b000);
    check("to_busy_after", busy, 1'b0);
`else
    ok = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (rsp_rdy !== 3'b000 || busy !== 1'b1) ok = 1'b0;
    end
    check("noto_wait_1000", ok, 1'b1);
    check("noto_data_hold", rsp_data, 32'hCAFE_F00D);
`endif
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
